ps2_kbd_ascii_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 70 +++++++
 rtl/ps2_kbd_ascii_rx_frame_rx.sv | 124 ++++++++++++
 rtl/ps2_kbd_ascii_rx.sv | 100 ++++++++++
 tb/tb_ps2_kbd_ascii_rx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// special scan codes, control characters and the scan-to-ASCII lookup.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DECODE
    } frame_state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;

    // Returns {mapped, ascii}; mapped=0 means the code produces no character.
    function automatic logic [8:0] scan_to_ascii(input logic [7:0] sc, input logic upper);
        logic [7:0] a;
        a = upper ? 8'h41 : 8'h61;
        case (sc)
            8'h1C: return {1'b1, a};
            8'h32: return {1'b1, a + 8'd1};
            8'h21: return {1'b1, a + 8'd2};
            8'h23: return {1'b1, a + 8'd3};
            8'h24: return {1'b1, a + 8'd4};
            8'h2B: return {1'b1, a + 8'd5};
            8'h34: return {1'b1, a + 8'd6};
            8'h33: return {1'b1, a + 8'd7};
            8'h43: return {1'b1, a + 8'd8};
            8'h3B: return {1'b1, a + 8'd9};
            8'h42: return {1'b1, a + 8'd10};
            8'h4B: return {1'b1, a + 8'd11};
            8'h3A: return {1'b1, a + 8'd12};
            8'h31: return {1'b1, a + 8'd13};
            8'h44: return {1'b1, a + 8'd14};
            8'h4D: return {1'b1, a + 8'd15};
            8'h15: return {1'b1, a + 8'd16};
            8'h2D: return {1'b1, a + 8'd17};
            8'h1B: return {1'b1, a + 8'd18};
            8'h2C: return {1'b1, a + 8'd19};
            8'h3C: return {1'b1, a + 8'd20};
            8'h2A: return {1'b1, a + 8'd21};
            8'h1D: return {1'b1, a + 8'd22};
            8'h22: return {1'b1, a + 8'd23};
            8'h35: return {1'b1, a + 8'd24};
            8'h1A: return {1'b1, a + 8'd25};
            8'h45: return {1'b1, 8'h30};
            8'h16: return {1'b1, 8'h31};
            8'h1E: return {1'b1, 8'h32};
            8'h26: return {1'b1, 8'h33};
            8'h25: return {1'b1, 8'h34};
            8'h2E: return {1'b1, 8'h35};
            8'h36: return {1'b1, 8'h36};
            8'h3D: return {1'b1, 8'h37};
            8'h3E: return {1'b1, 8'h38};
            8'h46: return {1'b1, 8'h39};
            8'h29: return {1'b1, CHAR_SPACE};
            8'h5A: return {1'b1, CHAR_CR};
            8'h66: return {1'b1, CHAR_BS};
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_kbd_ascii_rx_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// start/parity/stop validation and inter-edge timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    frame_state_t  state;
    logic          clk_meta, clk_sync, clk_prev;
    logic          dat_meta, dat_sync;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          par_err;
    logic [TW-1:0] tmo_cnt;
    logic          fall;
    logic          tmo_hit;

    assign fall      = clk_prev & ~clk_sync;
    assign tmo_hit   = (tmo_cnt == '0) && !fall;
    assign state_dbg = state;

    // Synchronizers idle high, matching an undriven PS/2 bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shreg       <= 8'h00;
            rx_byte     <= 8'h00;
            bitcnt      <= 3'd0;
            par_err     <= 1'b0;
            tmo_cnt     <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            if (fall)
                tmo_cnt <= TIMEOUT_RELOAD;
            else if (state inside {ST_DATA, ST_PARITY, ST_STOP} && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        if (!dat_sync) begin
                            state   <= ST_DATA;
                            bitcnt  <= 3'd0;
                            par_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (fall) begin
                        shreg  <= {dat_sync, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (fall) begin
                        par_err <= ~(^{shreg, dat_sync});
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (fall) begin
                        if (dat_sync && !par_err) begin
                            rx_byte     <= shreg;
                            byte_strobe <= 1'b1;
                            state       <= ST_DECODE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_ascii_rx.sv
// PS/2 keyboard to ASCII receiver with a one-entry valid/ack holding register.
// Define PS2_SHIFT_TRACK_EN to track left/right shift and emit uppercase letters.
module ps2_kbd_ascii_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ascii_data,
    output logic       ascii_valid,
    input  logic       ascii_ack,
    output logic [7:0] scan_code,
    output logic       frame_err,
    output logic       overrun
);

    logic [7:0] rx_byte;
    logic       byte_strobe;
    logic [2:0] frame_state;
    logic       decode_en;
    logic       brk, ext;
    logic       upper;
    logic [8:0] lut;

    ps2_frame_rx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_byte    (rx_byte),
        .byte_strobe(byte_strobe),
        .frame_err  (frame_err),
        .state_dbg  (frame_state)
    );

    // The strobe is only ever raised while the frame FSM sits in DECODE.
    assign decode_en = byte_strobe && (frame_state == ST_DECODE);
    assign lut       = scan_to_ascii(rx_byte, upper);

`ifdef PS2_SHIFT_TRACK_EN
    logic shift_held;
    logic is_shift;
    assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
    assign upper    = shift_held;
`else
    assign upper    = 1'b0;
`endif

    // Handoff: ascii_valid/ascii_ack; a load in the same cycle as an ack wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ascii_data  <= 8'h00;
            ascii_valid <= 1'b0;
            scan_code   <= 8'h00;
            overrun     <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
`ifdef PS2_SHIFT_TRACK_EN
            shift_held  <= 1'b0;
`endif
        end else begin
            if (ascii_ack && ascii_valid) begin
                ascii_valid <= 1'b0;
                overrun     <= 1'b0;
            end
            if (decode_en) begin
                scan_code <= rx_byte;
                if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (brk || ext) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
`ifdef PS2_SHIFT_TRACK_EN
                    if (brk && !ext && is_shift)
                        shift_held <= 1'b0;
                end else if (is_shift) begin
                    shift_held <= 1'b1;
`endif
                end else if (lut[8]) begin
                    if (!ascii_valid || ascii_ack) begin
                        ascii_data  <= lut[7:0];
                        ascii_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ascii_rx.sv
// Bench for ps2_kbd_ascii_rx: bit-banged PS/2 frames at ~15 kHz, a spec-level
// model of decode/handoff, per-cycle compare, and literal spot checks.
`timescale 1ns/1ps
module tb_ps2_kbd_ascii_rx;

    localparam int HALF_BIT = 33;  // clk cycles per PS/2 half period (1 MHz clk)

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       ascii_ack = 1'b0;
    logic [7:0] ascii_data, scan_code;
    logic       ascii_valid, frame_err, overrun;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // model state
    logic [7:0] m_scan = 8'h00;
    logic [7:0] m_data = 8'h00;
    bit m_valid = 0, m_overrun = 0, m_brk = 0, m_ext = 0, m_shift = 0;
    int err_exp = 0, err_seen = 0, dut_chars = 0;
    bit hold_off = 1;
    logic prev_err = 1'b0;

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    ps2_kbd_ascii_rx #(
        .CLK_FREQ_HZ(1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .ascii_data (ascii_data),
        .ascii_valid(ascii_valid),
        .ascii_ack  (ascii_ack),
        .scan_code  (scan_code),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    // clock / reset
    always #500 clk = ~clk;

    initial begin
        #100ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] sc, input bit up);
        for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) return (up ? 65 : 97) + i;
        for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) return 48 + i;
        if (sc == 8'h29) return 32;
        if (sc == 8'h5A) return 13;
        if (sc == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int c;
        m_scan = b;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (m_brk || m_ext) begin
`ifdef PS2_SHIFT_TRACK_EN
            if (m_brk && !m_ext && (b == 8'h12 || b == 8'h59)) m_shift = 0;
`endif
            m_brk = 0;
            m_ext = 0;
        end
`ifdef PS2_SHIFT_TRACK_EN
        else if (b == 8'h12 || b == 8'h59) m_shift = 1;
`endif
        else begin
            c = lookup(b, m_shift);
            if (c >= 0) begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_data  = c[7:0];
                    exp_q.push_back(c[7:0]);
                end else begin
                    m_overrun = 1;
                end
            end
        end
    endtask

    // driver tasks
    task automatic ps2_bit(input logic v);
        ps2_dat = v;
        repeat (HALF_BIT) @(posedge clk);
        #100 ps2_clk = 1'b0;
        repeat (HALF_BIT) @(posedge clk);
        #100 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_dat = 1'b1;
        repeat (HALF_BIT) @(posedge clk);
        #100;
        hold_off = 1;
        ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        #200;
        if (bad_par) err_exp++;
        else model_byte(b);
        hold_off = 0;
        repeat (HALF_BIT - 8) @(posedge clk);
        #100 ps2_clk = 1'b1;
        repeat (HALF_BIT + $urandom_range(0, 20)) @(posedge clk);
        #100;
        check("frame_err_count", err_seen, err_exp);
    endtask

    task automatic do_ack();
        logic [7:0] got;
        logic was_valid;
        @(posedge clk);
        #200;
        hold_off  = 1;
        got       = ascii_data;
        was_valid = ascii_valid;
        ascii_ack = 1'b1;
        @(posedge clk);
        #200;
        ascii_ack = 1'b0;
        if (was_valid) dut_chars++;
        if (m_valid) begin
            if (exp_q.size() > 0) check("ack_char", got, exp_q.pop_front());
            m_valid   = 0;
            m_overrun = 0;
        end
        hold_off = 0;
    endtask

    // scoreboard compare, every cycle on the falling clk edge
    always @(negedge clk) begin
        if (frame_err) begin
            err_seen++;
            check("frame_err_width", prev_err, 1'b0);
        end
        prev_err = frame_err;
        if (!hold_off) begin
            check("ascii_valid", ascii_valid, m_valid);
            check("scan_code", scan_code, m_scan);
            check("overrun", overrun, m_overrun);
            if (m_valid) check("ascii_data", ascii_data, m_data);
        end
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        #200;
        check("rst_ascii_valid", ascii_valid, 1'b0);
        check("rst_ascii_data", ascii_data, 8'h00);
        check("rst_scan_code", scan_code, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b1;
        hold_off = 0;
        repeat (5) @(posedge clk);
        #100;

        // single make code
        send_frame(8'h1C, 0);
        check("t1_scan", scan_code, 8'h1C);
        check("t1_data", ascii_data, 8'h61);
        check("t1_valid", ascii_valid, 1'b1);
        check("t1_no_err", err_seen, 0);
        do_ack();

        // make, break, make: only one character
        n0 = dut_chars;
        send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        do_ack();
        check("t2_chars", dut_chars - n0, 1);
        check("t2_scan", scan_code, 8'h1C);
        check("t2_valid", ascii_valid, 1'b0);

        // parity error
        send_frame(8'h16, 1);
        check("t3_err", err_seen, 1);
        check("t3_scan", scan_code, 8'h1C);
        check("t3_valid", ascii_valid, 1'b0);

        // partial frame then timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (250) @(posedge clk);
        #100;
        err_exp++;
        check("t4_timeout_err", err_seen, 2);
        send_frame(8'h45, 0);
        check("t4_data", ascii_data, 8'h30);
        do_ack();

        // overrun
        send_frame(8'h1C, 0);
        send_frame(8'h32, 0);
        check("t5_data", ascii_data, 8'h61);
        check("t5_overrun", overrun, 1'b1);
        do_ack();
        check("t5_valid_after_ack", ascii_valid, 1'b0);
        check("t5_overrun_after_ack", overrun, 1'b0);

        // bad start bit
        ps2_bit(1'b1);
        repeat (5) @(posedge clk);
        #100;
        err_exp++;
        check("t6_start_err", err_seen, 3);

        // control characters, extended, unmapped
        send_frame(8'h29, 0);
        check("t7_space", ascii_data, 8'h20);
        do_ack();
        send_frame(8'h5A, 0);
        check("t7_cr", ascii_data, 8'h0D);
        do_ack();
        send_frame(8'h66, 0);
        check("t7_bs", ascii_data, 8'h08);
        do_ack();
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        check("t7_ext_none", ascii_valid, 1'b0);
        send_frame(8'h76, 0);
        check("t7_unmapped", ascii_valid, 1'b0);
        send_frame(8'h59, 0);
        send_frame(8'h1C, 0);
`ifdef PS2_SHIFT_TRACK_EN
        check("t7_after_59", ascii_data, 8'h41);
`else
        check("t7_after_59", ascii_data, 8'h61);
`endif
        do_ack();

`ifdef PS2_SHIFT_TRACK_EN
        send_frame(8'hF0, 0);
        send_frame(8'h59, 0);
        send_frame(8'h12, 0);
        check("t8_shift_nochar", ascii_valid, 1'b0);
        send_frame(8'h1C, 0);
        check("t8_upper", ascii_data, 8'h41);
        do_ack();
        send_frame(8'hF0, 0);
        send_frame(8'h12, 0);
        send_frame(8'h1C, 0);
        check("t8_lower", ascii_data, 8'h61);
        do_ack();
`endif

        // reset mid-frame with a character held
        send_frame(8'h1C, 0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(posedge clk);
        #200;
        hold_off = 1;
        reset = 1'b0;
        #200;
        check("t9_rst_valid", ascii_valid, 1'b0);
        check("t9_rst_data", ascii_data, 8'h00);
        check("t9_rst_scan", scan_code, 8'h00);
        check("t9_rst_overrun", overrun, 1'b0);
        m_valid = 0; m_overrun = 0; m_brk = 0; m_ext = 0; m_shift = 0;
        m_scan = 8'h00; m_data = 8'h00;
        exp_q.delete();
        ps2_dat = 1'b1;
        repeat (3) @(posedge clk);
        #200;
        reset = 1'b1;
        hold_off = 0;
        repeat (5) @(posedge clk);
        #100;
        send_frame(8'h45, 0);
        check("t9_recover", ascii_data, 8'h30);
        do_ack();

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
